// File: rtl/sad_pkg.sv
// rtl/sad_pkg.sv - shared widths, helpers and state encoding for the SAD best-match stage
package sad_pkg;

    localparam int WIDTH_DEF = 8;

    // 32 absolute differences of w bits need w+5 bits to sum without overflow
    function automatic int sad_width(input int w);
        return w + 5;
    endfunction

    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = S_IDLE,
        ST_SEARCH = S_SEARCH,
        ST_DONE   = S_DONE
    } state_t;

endpackage

// File: rtl/sad_cmp_sel.sv
// rtl/sad_cmp_sel.sv - decides whether an incoming SAD replaces the running minimum
module sad_cmp_sel #(
    parameter int SAD_W = 13
) (
    input  logic             first,
    input  logic [SAD_W-1:0] sad_in,
    input  logic [SAD_W-1:0] best_sad,
    output logic             take
);

    // strict compare so ties keep the earlier candidate
    assign take = first | (sad_in < best_sad);

endmodule

// File: rtl/sad_best_match.sv
// rtl/sad_best_match.sv - tracks minimum SAD and its candidate index over one search window
module sad_best_match
    import sad_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int SAD_W    = sad_width(WIDTH),
    parameter int NUM_CAND = 16,
    parameter int IDX_W    = clog2_min1(NUM_CAND)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             sad_valid,
    input  logic [SAD_W-1:0] sad_in,
    input  logic             ack,
    output logic [SAD_W-1:0] best_sad,
    output logic [IDX_W-1:0] best_idx,
    output logic [IDX_W-1:0] cand_cnt,
    output logic             busy,
    output logic             done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

    state_t           state;
    state_t           state_n;
    logic             first;
    logic             first_n;
    logic [SAD_W-1:0] best_sad_n;
    logic [IDX_W-1:0] best_idx_n;
    logic [IDX_W-1:0] cand_cnt_n;
    logic             take;

    sad_cmp_sel #(
        .SAD_W(SAD_W)
    ) u_cmp (
        .first   (first),
        .sad_in  (sad_in),
        .best_sad(best_sad),
        .take    (take)
    );

    always_comb begin
        state_n    = state;
        first_n    = first;
        best_sad_n = best_sad;
        best_idx_n = best_idx;
        cand_cnt_n = cand_cnt;
        case (state)
            ST_SEARCH: begin
                // a restart wins over a sample arriving in the same cycle
                if (init) begin
                    cand_cnt_n = '0;
                    first_n    = 1'b1;
                end else if (sad_valid) begin
                    if (take) begin
                        best_sad_n = sad_in;
                        best_idx_n = cand_cnt;
                    end
                    first_n    = 1'b0;
                    cand_cnt_n = cand_cnt + 1'b1;
                    if (cand_cnt == LAST_IDX) begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (ack) begin
                    if (init) begin
                        state_n    = ST_SEARCH;
                        cand_cnt_n = '0;
                        first_n    = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                // covers IDLE and the unused encoding
                state_n = ST_IDLE;
                if (init) begin
                    state_n    = ST_SEARCH;
                    cand_cnt_n = '0;
                    first_n    = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            first    <= 1'b0;
            best_sad <= '0;
            best_idx <= '0;
            cand_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            first    <= first_n;
            best_sad <= best_sad_n;
            best_idx <= best_idx_n;
            cand_cnt <= cand_cnt_n;
            busy     <= (state_n == ST_SEARCH);
            done     <= (state_n == ST_DONE);
        end
    end

endmodule

// File: tb/tb_sad_best_match.sv
// tb/tb_sad_best_match.sv - directed and randomized checks of sad_best_match against a queue model
module tb_sad_best_match;

    localparam int NUM_CAND = 4;
    localparam int WIDTH    = 8;
    localparam int SAD_W    = 13;
    localparam int IDX_W    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             init;
    logic             sad_valid;
    logic [SAD_W-1:0] sad_in;
    logic             ack;
    logic [SAD_W-1:0] best_sad;
    logic [IDX_W-1:0] best_idx;
    logic [IDX_W-1:0] cand_cnt;
    logic             busy;
    logic             done;

    sad_best_match #(
        .WIDTH   (WIDTH),
        .SAD_W   (SAD_W),
        .NUM_CAND(NUM_CAND),
        .IDX_W   (IDX_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .init     (init),
        .sad_valid(sad_valid),
        .sad_in   (sad_in),
        .ack      (ack),
        .best_sad (best_sad),
        .best_idx (best_idx),
        .cand_cnt (cand_cnt),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model: 0 idle, 1 searching, 2 result presented
    int mode;
    int samples[$];
    int e_sad;
    int e_idx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mode = 0;
        samples.delete();
        e_sad = 0;
        e_idx = 0;
    endtask

    task automatic recompute_best();
        e_sad = samples[0];
        e_idx = 0;
        foreach (samples[k]) begin
            if (samples[k] < e_sad) begin
                e_sad = samples[k];
                e_idx = k;
            end
        end
    endtask

    task automatic model_edge(input bit i, input bit v, input int s, input bit a);
        case (mode)
            0: if (i) begin
                mode = 1;
                samples.delete();
            end
            1: if (i) begin
                samples.delete();
            end else if (v) begin
                samples.push_back(s);
                recompute_best();
                if (samples.size() == NUM_CAND) mode = 2;
            end
            default: if (a) begin
                if (i) begin
                    mode = 1;
                    samples.delete();
                end else begin
                    mode = 0;
                end
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        check({tag, ".best_sad"}, 32'(best_sad), 32'(e_sad));
        check({tag, ".best_idx"}, 32'(best_idx), 32'(e_idx));
        check({tag, ".cand_cnt"}, 32'(cand_cnt), 32'(samples.size() % (1 << IDX_W)));
        check({tag, ".busy"}, 32'(busy), 32'(mode == 1));
        check({tag, ".done"}, 32'(done), 32'(mode == 2));
    endtask

    task automatic step(input string tag, input bit i, input bit v, input int s, input bit a);
        init      = i;
        sad_valid = v;
        sad_in    = SAD_W'(s);
        ack       = a;
        @(posedge clk);
        #1;
        model_edge(i, v, s, a);
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1;
        init = 1'b0;
        sad_valid = 1'b0;
        sad_in = '0;
        ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset.best_sad", 32'(best_sad), 32'd0);
        check("reset.best_idx", 32'(best_idx), 32'd0);
        check("reset.cand_cnt", 32'(cand_cnt), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        rst = 1'b0;

        // basic search, result held until ack
        step("basic.init", 1, 0, 0, 0);
        step("basic.s0", 0, 1, 100, 0);
        step("basic.s1", 0, 1, 50, 0);
        step("basic.s2", 0, 1, 75, 0);
        step("basic.s3", 0, 1, 60, 0);
        check("basic.done_best", 32'(best_sad), 32'd50);
        check("basic.done_idx", 32'(best_idx), 32'd1);
        step("basic.hold0", 0, 0, 0, 0);
        step("basic.hold1", 0, 1, 3, 0);
        step("basic.ack", 0, 0, 0, 1);
        check("basic.done_low", 32'(done), 32'd0);

        // ties and all-ones
        step("tie.init", 1, 0, 0, 0);
        repeat (4) step("tie.max", 0, 1, 8191, 0);
        check("tie.max_best", 32'(best_sad), 32'd8191);
        step("tie.ack_init", 1, 0, 0, 1);
        check("tie.busy_direct", 32'(busy), 32'd1);
        step("tie.s0", 0, 1, 30, 0);
        step("tie.s1", 0, 1, 30, 0);
        step("tie.s2", 0, 1, 40, 0);
        step("tie.s3", 0, 1, 30, 0);
        check("tie.idx0", 32'(best_idx), 32'd0);
        step("tie.ack", 0, 0, 0, 1);

        // gapped valid
        step("gap.init", 1, 0, 0, 0);
        step("gap.s0", 0, 1, 90, 0);
        step("gap.g0", 0, 0, 7, 0);
        step("gap.g1", 0, 0, 7, 0);
        step("gap.s1", 0, 1, 20, 0);
        step("gap.g2", 0, 0, 7, 0);
        step("gap.s2", 0, 1, 20, 0);
        step("gap.s3", 0, 1, 5, 0);
        check("gap.idx3", 32'(best_idx), 32'd3);
        step("gap.ack", 0, 0, 0, 1);

        // abort and restart with a discarded sample
        step("abort.init", 1, 0, 0, 0);
        step("abort.s0", 0, 1, 10, 0);
        step("abort.s1", 0, 1, 10, 0);
        step("abort.restart", 1, 1, 1, 0);
        step("abort.s2", 0, 1, 40, 0);
        step("abort.s3", 0, 1, 35, 0);
        step("abort.s4", 0, 1, 45, 0);
        step("abort.s5", 0, 1, 50, 0);
        check("abort.best", 32'(best_sad), 32'd35);
        check("abort.idx", 32'(best_idx), 32'd1);

        // handshake corners
        step("hs.init_no_ack0", 1, 0, 0, 0);
        step("hs.init_no_ack1", 1, 1, 2, 0);
        step("hs.ack", 0, 0, 0, 1);
        step("hs.idle_valid0", 0, 1, 1, 0);
        step("hs.idle_valid1", 0, 1, 1, 0);

        // asynchronous reset in mid-search
        step("rst.init", 1, 0, 0, 0);
        step("rst.s0", 0, 1, 300, 0);
        step("rst.s1", 0, 1, 200, 0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst.async");
        #1;
        rst = 1'b0;
        step("rst.idle_valid0", 0, 1, 4, 0);
        step("rst.idle_valid1", 0, 1, 4, 0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            bit ri, rv, ra;
            int rs;
            ri = ($urandom_range(0, 19) == 0);
            rv = ($urandom_range(0, 2) != 0);
            ra = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8191)) : int'($urandom_range(0, 12));
            step("rand", ri, rv, rs, ra);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sad_best_match.md
Name: sad_best_match

Overview:
- Downstream consumer of the pipelined 32-pixel SAD datapath (`top_level`).
- Takes the stream of `out_sad` values for consecutive candidate blocks of one search window and tracks the minimum SAD and its candidate index.
- Presents the winner with a `done`/`ack` handshake to the motion-vector / control stage.
- One search = NUM_CAND valid SAD samples.

Parameters:
- WIDTH, 8, pixel width; must match the SAD datapath.
- SAD_W, WIDTH+5, SAD width (32 absolute differences of WIDTH bits).
- NUM_CAND, 16, candidates per search window; legal range 1..2^IDX_W.
- IDX_W, 4, candidate index width, equal to clog2(NUM_CAND), minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- init  in  1  start a new search; sampled on the rising edge.
- sad_valid  in  1  sad_in holds the SAD of the next candidate this cycle.
- sad_in  in  SAD_W  SAD value from the datapath.
- ack  in  1  consumer has taken the result.
- best_sad  out  SAD_W  minimum SAD of the search.
- best_idx  out  IDX_W  candidate index of best_sad (0 = first sample).
- cand_cnt  out  IDX_W  number of samples accepted so far in the current search.
- busy  out  1  high in SEARCH.
- done  out  1  high in DONE; result valid.

Behaviour:
- Reset (async, any state): state=IDLE; best_sad=0, best_idx=0, cand_cnt=0, busy=0, done=0. All outputs are registered.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - init=1 -> SEARCH next cycle; cand_cnt=0; a first flag is set.
  - sad_valid is ignored in IDLE.
- SEARCH:
  - busy=1.
  - Each cycle with sad_valid=1, a sample is accepted:
    - If first flag is set, or sad_in < best_sad (strict, unsigned): load best_sad=sad_in and best_idx=cand_cnt.
    - Clear first flag; cand_cnt++.
  - Ties keep the earlier index. The first sample always loads, so an all-ones SAD is still captured.
  - Gaps in sad_valid are allowed; state and registers hold during gaps.
  - The sample with cand_cnt==NUM_CAND-1 is the final one: it is compared normally, and the next state is DONE with busy=0 and done=1.
  - cand_cnt reads NUM_CAND mod 2^IDX_W in DONE. This wraps to 0 when NUM_CAND=2^IDX_W.
  - Latency: done rises on the first clock edge after the last valid sample (1 cycle).
  - init=1 in SEARCH aborts and restarts: cand_cnt=0, first flag set. Any sad_valid in that same cycle is discarded.
- DONE:
  - done=1; best_sad and best_idx are held stable until ack.
  - ack=1 -> IDLE; done=0 next cycle.
  - ack=1 and init=1 together -> SEARCH directly; done=0 and busy=1 next cycle.
  - init without ack is ignored. sad_valid is ignored.
- best_sad and best_idx keep the last result in IDLE and until the first accepted sample of the next search.
- Arithmetic: comparison only, no overflow possible; sad_in is taken unsigned at full SAD_W.
- NUM_CAND=1: the first valid sample goes straight to DONE with best_idx=0.

Decomposition:
- Shared package `sad_pkg`:
  - WIDTH default.
  - SAD_W derivation function (WIDTH+5).
  - clog2 helper.
  - State encoding localparams (S_IDLE=2'd0, S_SEARCH=2'd1, S_DONE=2'd2); encoding 2'd3 decodes to IDLE.
- One sub-module is natural: `sad_cmp_sel`, combinational. Inputs first, sad_in, best_sad; output take. Reusable by a future parallel-tree minimum stage.
- FSM, counter and registers live in sad_best_match.

Test Plan:
- Bench uses NUM_CAND=4 throughout.
- Basic: init, then sad_in 100, 50, 75, 60 on consecutive cycles -> done one cycle after the 4th sample; best_sad=50, best_idx=1, cand_cnt=0; held until ack; done=0 the cycle after ack.
- Ties and extremes: 8191, 8191, 8191, 8191 -> best_sad=8191, best_idx=0. Then 30, 30, 40, 30 -> best_sad=30, best_idx=0.
- Gapped valid: 90, gap, gap, 20, gap, 20, 5 -> best_sad=5, best_idx=3; busy stays 1 through the gaps; done only after the 4th valid sample.
- Abort/restart: 10, 10, then init plus a valid 1 in the same cycle, then 40, 35, 45, 50 -> best_sad=35, best_idx=1 (the 1 is discarded).
- Reset mid-search: after 2 samples, pulse rst between edges -> all outputs 0 immediately; state IDLE; subsequent sad_valid is ignored until init.
- Handshake corners:
  - Holding init in DONE without ack -> no change.
  - ack with init in DONE -> busy=1 next cycle.
  - sad_valid asserted in IDLE -> cand_cnt stays 0.
